// File: rtl/saida_buffer_pkg.sv
// Shared defaults and derived widths for the saida sample buffer.
package saida_buffer_pkg;

    localparam int SAIDA_WIDTH = 16;
    localparam int SAIDA_DEPTH = 8;
    localparam int SAIDA_PTR_W = $clog2(SAIDA_DEPTH);
    localparam int SAIDA_CNT_W = SAIDA_PTR_W + 1;

endpackage

// File: rtl/saida_change_det.sv
// Qualifies a sample only when it differs from the last qualified one; the first sample after reset always qualifies.
// Zero latency (combinational qualify), no backpressure: dropped samples still update the last-sample register.
module saida_change_det #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             qualified
);

    logic [WIDTH-1:0] last_sample;
    logic             armed;

    assign qualified = in_valid && (!armed || (in_data != last_sample));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_sample <= '0;
            armed       <= 1'b0;
        end else if (qualified) begin
            last_sample <= in_data;
            armed       <= 1'b1;
        end
    end

endmodule

// File: rtl/saida_buffer.sv
// FIFO for the saida output stream; define SAIDA_BUFFER_CHANGE_DETECT_EN to store only changed samples.
// Head appears the cycle after the push (no bypass); when full, new samples are dropped and overflow sticks unless a pop frees a slot.
module saida_buffer
    import saida_buffer_pkg::*;
#(
    parameter int WIDTH = SAIDA_WIDTH,
    parameter int DEPTH = SAIDA_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             qualified;
    logic             push;
    logic             pop;
    logic             drop;

`ifdef SAIDA_BUFFER_CHANGE_DETECT_EN
    saida_change_det #(
        .WIDTH(WIDTH)
    ) u_change_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .qualified(qualified)
    );
`else
    assign qualified = in_valid;
`endif

    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];

    always_comb begin
        pop       = out_valid && out_ready;
        push      = qualified && (!full || pop);
        drop      = qualified && full && !pop;
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Storage is intentionally left uncleared by reset.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_saida_buffer.sv
// Directed self-checking bench for saida_buffer (default DEPTH=8, WIDTH=16).
module tb_saida_buffer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
    logic             full;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    saida_buffer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] cd_exp [$];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("reset_count",     32'(count),     32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_full",      32'(full),      32'd0);
        check("reset_overflow",  32'(overflow),  32'd0);

        // Three pushes, then three pops in order
        for (int v = 1; v <= 3; v++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(v);
            tick();
            if (v == 1) begin
                check("latency_out_valid", 32'(out_valid), 32'd1);
                check("latency_out_data",  32'(out_data),  32'd1);
            end
        end
        in_valid = 1'b0;
        check("three_count", 32'(count),    32'd3);
        check("three_head",  32'(out_data), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("three_pop_data", 32'(out_data), 32'(i + 1));
            tick();
        end
        out_ready = 1'b0;
        check("three_drained_count", 32'(count),     32'd0);
        check("three_drained_valid", 32'(out_valid), 32'd0);

        // No bypass when pushing into an empty FIFO with out_ready high
        in_valid  = 1'b1;
        in_data   = 16'd42;
        out_ready = 1'b1;
        #1;
        check("nobypass_valid_same_cycle", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check("nobypass_count", 32'(count),    32'd1);
        check("nobypass_data",  32'(out_data), 32'd42);
        tick();
        check("nobypass_popped", 32'(count), 32'd0);
        tick();
        check("ready_while_empty_count", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Fill 10..17, then drop 99
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(10 + i);
            tick();
        end
        check("fill_full",     32'(full),     32'd1);
        check("fill_count",    32'(count),    32'd8);
        check("fill_overflow", 32'(overflow), 32'd0);
        in_data = 16'd99;
        tick();
        in_valid = 1'b0;
        check("drop_overflow", 32'(overflow), 32'd1);
        check("drop_count",    32'(count),    32'd8);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drop_drain_data", 32'(out_data), 32'(10 + i));
            tick();
        end
        out_ready = 1'b0;
        check("drop_drained_count", 32'(count),    32'd0);
        check("overflow_sticky",    32'(overflow), 32'd1);

        // Reset with 4 entries stored and push/pop attempted in the reset cycle
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(200 + i);
            tick();
        end
        check("pre_reset_count", 32'(count), 32'd4);
        rst_n     = 1'b0;
        in_data   = 16'd204;
        out_ready = 1'b1;
        tick();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("midreset_count",    32'(count),     32'd0);
        check("midreset_valid",    32'(out_valid), 32'd0);
        check("midreset_overflow", 32'(overflow),  32'd0);
        check("midreset_full",     32'(full),      32'd0);

        // Full FIFO with push and pop in the same cycle
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(60 + i);
            tick();
        end
        in_data   = 16'd50;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("fullpp_count",    32'(count),    32'd8);
        check("fullpp_full",     32'(full),     32'd1);
        check("fullpp_overflow", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("fullpp_drain_data", 32'(out_data), (i < 7) ? 32'(61 + i) : 32'd50);
            tick();
        end
        check("fullpp_drained_count", 32'(count), 32'd0);

        // Continuous streaming across pointer wraps
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(100 + i);
            if (i > 0) begin
                check("stream_valid", 32'(out_valid), 32'd1);
                check("stream_data",  32'(out_data),  32'(100 + i - 1));
            end
            tick();
        end
        in_valid = 1'b0;
        check("stream_count_steady", 32'(count),    32'd1);
        check("stream_last",         32'(out_data), 32'd119);
        tick();
        out_ready = 1'b0;
        check("stream_drained_count", 32'(count), 32'd0);

        // Change-detect behaviour: 5,5,5,7,7,5 with in_valid held high
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
`ifdef SAIDA_BUFFER_CHANGE_DETECT_EN
        cd_exp = '{16'd5, 16'd7, 16'd5};
`else
        cd_exp = '{16'd5, 16'd5, 16'd5, 16'd7, 16'd7, 16'd5};
`endif
        in_valid = 1'b1;
        in_data  = 16'd5; tick();
        in_data  = 16'd5; tick();
        in_data  = 16'd5; tick();
        in_data  = 16'd7; tick();
        in_data  = 16'd7; tick();
        in_data  = 16'd5; tick();
        in_valid = 1'b0;
        check("cd_count", 32'(count), 32'(cd_exp.size()));
        out_ready = 1'b1;
        foreach (cd_exp[i]) begin
            check("cd_data", 32'(out_data), 32'(cd_exp[i]));
            tick();
        end
        out_ready = 1'b0;
        check("cd_drained_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/saida_buffer.md
SAIDA_BUFFER -- requirements
Module: saida_buffer

Interface
REQ-001 Parameter WIDTH, default 16, sample width; matches the 16-bit system output "saida".
REQ-002 Parameter DEPTH, default 8, FIFO entries; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  in_data is a sample offered this cycle.
REQ-006 in_data  input  WIDTH  sample from the upstream system output.
REQ-007 out_valid  output  1  out_data holds the oldest stored sample.
REQ-008 out_ready  input  1  consumer accepts out_data this cycle.
REQ-009 out_data  output  WIDTH  head-of-FIFO sample.
REQ-010 count  output  $clog2(DEPTH)+1  stored entries, 0..DEPTH.
REQ-011 full  output  1  count == DEPTH.
REQ-012 overflow  output  1  sticky: a qualified sample was dropped.

Function
REQ-013 A sample is qualified when in_valid=1 and, with the change-detect feature compiled in, in_data differs from the last qualified sample.
REQ-014 Push occurs on a qualified sample when full=0, or when full=1 and a pop occurs in the same cycle.
REQ-015 Pop occurs when out_valid=1 and out_ready=1.
REQ-016 out_valid SHALL equal (count != 0); out_data SHALL present the head entry combinationally from storage, with no extra register stage.
REQ-017 Latency: a sample pushed at edge N SHALL appear at out_data with out_valid=1 in the cycle after edge N when the FIFO was empty.
REQ-018 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-019 Push while empty with out_ready=1 SHALL NOT bypass; the sample is stored and out_valid rises next cycle.
REQ-020 Qualified sample while full with no pop SHALL be dropped, storage unchanged, overflow set to 1 at the next edge.
REQ-021 overflow SHALL remain 1 until reset.
REQ-022 Read and write pointers SHALL each wrap from DEPTH-1 to 0.
REQ-023 out_ready while out_valid=0 SHALL have no effect.
REQ-024 full and count SHALL be registered state, updated the same edge as the push/pop.

Reset
REQ-025 On a clk edge with rst_n=0: pointers=0, count=0, full=0, out_valid=0, overflow=0, last-sample register=0, change-detect armed-flag=0.
REQ-026 out_data after reset is don't-care; storage contents are not cleared.
REQ-027 Reset asserted mid-operation SHALL discard all stored entries; a push or pop in that cycle is ignored.

Configuration
REQ-028 Macro SAIDA_BUFFER_CHANGE_DETECT_EN.
REQ-029 Defined: only samples differing from the last qualified sample qualify; the first in_valid after reset always qualifies (armed-flag); the last-sample register updates on every qualified sample, including a dropped one.
REQ-030 Undefined: every in_valid=1 cycle qualifies; no last-sample register or armed-flag is built.

Structure
REQ-031 Package saida_buffer_pkg SHALL hold WIDTH/DEPTH defaults and the derived pointer and count width constants.
REQ-032 Change detection SHALL be a sub-module saida_change_det (clk, rst_n, in_valid, in_data -> qualified), instantiated only when the macro is defined.

Verification
REQ-033 Reset, then push 1,2,3 on consecutive cycles with out_ready=0 -> count=3, out_data=1; then out_ready=1 for 3 cycles -> pops 1,2,3 in order, count=0, out_valid=0.
REQ-034 Push 8 samples 10..17, then a 9th (99) with out_ready=0 -> full=1, overflow=1, 99 absent; drained order is 10..17.
REQ-035 Full FIFO, push 50 with out_ready=1 in the same cycle -> count stays 8, overflow=0, 50 emerges last.
REQ-036 Stream 20 samples with continuous push and pop -> pointer wrap is exercised and output order is identical to input order.
REQ-037 Macro defined: in_valid held high with in_data 5,5,5,7,7,5 -> stored 5,7,5 only; macro undefined -> 6 entries stored.
REQ-038 rst_n=0 for one cycle with 4 entries stored -> next cycle count=0, out_valid=0, overflow=0.
